fetch_ctrl: RTL
===============

# fetch_ctrl

Instruction fetch controller that sequences reads from the 16-bit instruction memory and feeds a decode stage through a valid/ready handshake. Holds the PC, issues one read per cycle when buffer space allows, and absorbs the memory's one-cycle registered read latency in a small prefetch FIFO. Handles branch/jump redirects by squashing in-flight and buffered instructions, and supports a fetch halt. Sits between the instruction memory and the decode stage of the CPU.

## Interface
- ADDR_W, 16, instruction address width (byte address)
- DATA_W, 16, instruction width
- RESET_PC, 16'h0000, PC loaded on reset
- PC_STEP, 2, byte increment per instruction
- FIFO_DEPTH, 2, prefetch buffer entries (power of two, ≥2)
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- imem_addr  out  ADDR_W  read address to instruction memory
- imem_rd  out  1  read request; address sampled at clk edge
- imem_data  in  DATA_W  read data, valid the cycle after the request
- inst  out  DATA_W  instruction at FIFO head
- inst_pc  out  ADDR_W  address of inst
- inst_valid  out  1  head entry valid
- inst_ready  in  1  decode accepts head this cycle
- redirect  in  1  branch/jump taken; flush and refetch
- redirect_pc  in  ADDR_W  new fetch address
- halt  in  1  stop issuing new reads while high

## Operation
- FSM: S_BOOT → S_RUN ↔ S_HALT. S_BOOT lasts exactly one cycle after rst deasserts (memory settles); no reads issued in S_BOOT.
- S_RUN: imem_rd = 1 when (count + inflight − pop) < FIFO_DEPTH and redirect = 0; imem_addr = pc; pc ← pc + PC_STEP on issue. pop = inst_valid & inst_ready.
- Data return: inflight flag set on issue; next cycle imem_data pushed with its PC unless squashed.
- Pop: head advances when inst_valid & inst_ready; push and pop in same cycle both take effect, count unchanged.
- redirect (any state except S_BOOT): FIFO flushed, in-flight return squashed, pc ← {redirect_pc[ADDR_W-1:1], 1'b0}; no read issued in the redirect cycle. Redirect overrides pop, push and halt transitions.
- halt = 1: S_RUN → S_HALT; no new reads; in-flight return still captured; FIFO still drains. halt = 0: S_HALT → S_RUN, fetch resumes at pc.
- PC arithmetic modulo 2^ADDR_W: 16'hFFFE + 2 = 16'h0000, no flag.
- Reset mid-operation: all state returns to reset values immediately; pending returns discarded.

## Timing
- Reset values: imem_addr = RESET_PC, imem_rd = 0, inst = 0, inst_pc = 0, inst_valid = 0, state S_BOOT, count = 0, inflight = 0.
- First read: second rising edge after rst deasserts; inst_valid first high the cycle after data returns.
- Latency: request in cycle N → data captured end of N+1 → inst_valid from N+2.
- Throughput: one instruction/cycle sustained with inst_ready held high and FIFO_DEPTH ≥ 2.
- Redirect in cycle N: inst_valid low in N+1; read of redirect_pc in N+1; new inst_valid from N+3.
- inst/inst_pc stable while inst_valid & !inst_ready (no redirect).
- imem_rd and imem_addr are combinational from registered state; no input-to-imem_rd path except redirect and inst_ready.

## Configuration
- FETCH_PERF_EN defined: adds outputs perf_fetched (16) and perf_squashed (16), saturating counters of pushed and squashed/flushed instructions, reset to 0.
- Undefined: ports and counters absent; functional behaviour identical.

## Structure
- Shared package fetch_pkg: FSM state encoding (S_BOOT, S_RUN, S_HALT), RESET_PC, PC_STEP, ADDR_W/DATA_W defaults.
- One sub-module: fetch_fifo (parameterised DEPTH, {pc, inst} entries, push/pop/flush, count output).
- Top holds FSM, PC, inflight/squash flag and credit logic.

## Test plan
- Reset release, inst_ready = 1, memory 0x00→0x1120, 0x02→0x11D1 → imem_rd first on 2nd edge at 0x0000; inst 0x1120/pc 0x0000 then 0x11D1/pc 0x0002 on consecutive cycles.
- inst_ready = 0 for 5 cycles → FIFO fills to FIFO_DEPTH, imem_rd drops, inst holds 0x1120; release → in-order delivery, no loss or duplication.
- redirect with redirect_pc = 0x0021 while FIFO full and read in flight → inst_valid low next cycle, next read at 0x0020, next delivered inst_pc = 0x0020.
- halt high 4 cycles mid-stream → no imem_rd during halt, buffered/in-flight entries still delivered; resume at next sequential PC.
- RESET_PC = 0xFFFC, free-run → inst_pc sequence 0xFFFC, 0xFFFE, 0x0000, 0x0002.
- rst asserted with valid entries → inst_valid = 0 immediately; restart fetches from RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_pkg : shared FSM encoding and default geometry for the fetch block.
// Rev 1.0
// ----------------------------------------------------------------------------
package fetch_pkg;

   localparam int          ADDR_W_DEF   = 16;
   localparam int          DATA_W_DEF   = 16;
   localparam logic [15:0] RESET_PC_DEF = 16'h0000;
   localparam int          PC_STEP_DEF  = 2;

   typedef enum logic [1:0] {
      S_BOOT = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_fifo : small prefetch buffer of {pc, inst} entries with flush.
// Rev 1.0
// ----------------------------------------------------------------------------
module fetch_fifo
#(
   parameter  int DEPTH = 2,
   parameter  int WIDTH = 32,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             do_push, do_pop;

   always_comb begin
      mem_d   = mem_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      cnt_d   = cnt_q;
      do_pop  = pop & (cnt_q != '0);
      // A full buffer may still accept when the head leaves in the same cycle.
      do_push = push & ((cnt_q != CNT_W'(DEPTH)) | do_pop);
      if (flush) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_q] = wdata;
            wr_d        = wr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_d = rd_q + PTR_W'(1);
         end
         cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   assign rdata = mem_q[rd_q];
   assign count = cnt_q;

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_ctrl : PC sequencer feeding decode through a prefetch FIFO.
// Define FETCH_PERF_EN to add perf_fetched/perf_squashed counters. Rev 1.0
// ----------------------------------------------------------------------------
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int                ADDR_W     = ADDR_W_DEF,
   parameter int                DATA_W     = DATA_W_DEF,
   parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(RESET_PC_DEF),
   parameter int                PC_STEP    = PC_STEP_DEF,
   parameter int                FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] imem_addr,
   output logic              imem_rd,
   input  logic [DATA_W-1:0] imem_data,
   output logic [DATA_W-1:0] inst,
   output logic [ADDR_W-1:0] inst_pc,
   output logic              inst_valid,
   input  logic              inst_ready,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              halt
`ifdef FETCH_PERF_EN
   ,
   output logic [15:0]       perf_fetched,
   output logic [15:0]       perf_squashed
`endif
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   fetch_state_e             state_q, state_d;
   logic [ADDR_W-1:0]        pc_q, pc_d;
   logic [ADDR_W-1:0]        ret_pc_q, ret_pc_d;
   logic                     inflight_q, inflight_d;
   logic [CNT_W-1:0]         fifo_count;
   logic [CNT_W:0]           occupancy;
   logic                     redirect_act, pop, push, issue;
   logic [ADDR_W+DATA_W-1:0] head;

   assign inst_valid = (fifo_count != '0);

   always_comb begin
      redirect_act = redirect & (state_q != S_BOOT);
      pop          = inst_valid & inst_ready;
      // A redirect squashes the read returning this cycle.
      push         = inflight_q & ~redirect_act;
      occupancy    = {1'b0, fifo_count} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
      issue        = (state_q == S_RUN) & ~redirect_act
                   & (occupancy < (CNT_W+1)'(FIFO_DEPTH));
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ret_pc_d   = ret_pc_q;
      inflight_d = issue;
      case (state_q)
         S_BOOT:  state_d = S_RUN;
         S_RUN:   if (halt && !redirect_act) state_d = S_HALT;
         S_HALT:  if (!halt && !redirect_act) state_d = S_RUN;
         default: state_d = S_BOOT;
      endcase
      if (redirect_act) begin
         pc_d = redirect_pc & ~ADDR_W'(1);
      end else if (issue) begin
         pc_d     = pc_q + ADDR_W'(PC_STEP);
         ret_pc_d = pc_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_BOOT;
         pc_q       <= RESET_PC;
         ret_pc_q   <= '0;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ret_pc_q   <= ret_pc_d;
         inflight_q <= inflight_d;
      end
   end

   assign imem_rd   = issue;
   assign imem_addr = pc_q;

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ADDR_W + DATA_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (redirect_act),
      .wdata ({ret_pc_q, imem_data}),
      .rdata (head),
      .count (fifo_count)
   );

   assign inst    = head[DATA_W-1:0];
   assign inst_pc = head[ADDR_W+DATA_W-1:DATA_W];

`ifdef FETCH_PERF_EN
   logic [15:0] perf_fetched_q, perf_fetched_d;
   logic [15:0] perf_squashed_q, perf_squashed_d;
   logic [17:0] squash_sum;

   always_comb begin
      perf_fetched_d = perf_fetched_q;
      if (push && (perf_fetched_q != 16'hFFFF)) begin
         perf_fetched_d = perf_fetched_q + 16'd1;
      end
      // Squashed work is the buffered entries plus any read returning now.
      squash_sum = {2'b00, perf_squashed_q} + 18'(fifo_count)
                 + 18'(inflight_q & redirect_act);
      perf_squashed_d = perf_squashed_q;
      if (redirect_act) begin
         perf_squashed_d = (squash_sum > 18'h0FFFF) ? 16'hFFFF : squash_sum[15:0];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_fetched_q  <= '0;
         perf_squashed_q <= '0;
      end else begin
         perf_fetched_q  <= perf_fetched_d;
         perf_squashed_q <= perf_squashed_d;
      end
   end

   assign perf_fetched  = perf_fetched_q;
   assign perf_squashed = perf_squashed_q;
`endif

endmodule
`default_nettype wire
